hls_macc_nc_key_loader: RTL

Upstream key-provisioning stage for the locked `hls_macc_nc` multiply-accumulate core. It accepts the 3071-bit working key as a stream of 32-bit words from the host or key-storage bus, verifies an XOR checksum and holds the key in a register that drives the core's `working_key` port. It also gates the core's `ap_start`, so the core can only be launched while a verified key is loaded.

---
 rtl/hls_macc_nc_pkg.sv | 16 +
 rtl/hls_macc_nc_key_loader.sv | 118 +++++++++++
 2 files changed

// File: rtl/hls_macc_nc_pkg.sv
// Shared constants and the loader state type for the hls_macc_nc key-provisioning slice.
package hls_macc_nc_pkg;

    localparam int KEY_W  = 3071;
    localparam int WORD_W = 32;
    localparam int NWORDS = 96;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED,
        ERR
    } key_ld_state_t;

endpackage : hls_macc_nc_pkg

// File: rtl/hls_macc_nc_key_loader.sv
// Streams the working key in 32-bit words, verifies an XOR checksum word and
// only lets the host launch the core while a verified key is held.
module hls_macc_nc_key_loader #(
    parameter int KEY_W  = 3071,
    parameter int WORD_W = 32,
    parameter int NWORDS = 96
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              load_start,
    input  logic              key_clr,
    input  logic [WORD_W-1:0] key_word,
    input  logic              key_word_vld,
    output logic              key_word_rdy,
    output logic [KEY_W-1:0]  working_key,
    output logic              key_ready,
    output logic              key_err,
    input  logic              host_start,
    output logic              ap_start_out
);
    import hls_macc_nc_pkg::CNT_W;
    import hls_macc_nc_pkg::key_ld_state_t;
    import hls_macc_nc_pkg::IDLE;
    import hls_macc_nc_pkg::LOAD;
    import hls_macc_nc_pkg::ARMED;
    import hls_macc_nc_pkg::ERR;

    key_ld_state_t     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] fold_q;
    logic              key_ready_q;
    logic              key_err_q;

    logic              word_hs;
    logic              cksum_phase;
    logic              cksum_bad;
    logic              key_wipe;

    assign key_word_rdy = (state_q == LOAD);

    // A word offered in the same cycle as load_start/key_clr is discarded.
    assign word_hs     = key_word_vld && key_word_rdy && !load_start && !key_clr;
    assign cksum_phase = (cnt_q == CNT_W'(NWORDS));
    assign cksum_bad   = word_hs && cksum_phase && (key_word != fold_q);
    assign key_wipe    = key_clr || load_start || cksum_bad;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fold_q      <= '0;
            key_ready_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else if (key_clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fold_q      <= '0;
            key_ready_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else if (load_start) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            fold_q      <= '0;
            key_ready_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (word_hs) begin
                        if (cksum_phase) begin
                            if (key_word == fold_q) begin
                                state_q     <= ARMED;
                                key_ready_q <= 1'b1;
                            end else begin
                                state_q   <= ERR;
                                key_err_q <= 1'b1;
                            end
                        end else begin
                            fold_q <= fold_q ^ key_word;
                            cnt_q  <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One register slice per key word; the top slice is narrower and drops
    // the word bits that fall beyond KEY_W.
    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_slice
            localparam int LO = gi * WORD_W;
            localparam int SW = ((KEY_W - LO) < WORD_W) ? (KEY_W - LO) : WORD_W;

            logic [SW-1:0] slice_q;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    slice_q <= '0;
                end else if (key_wipe) begin
                    slice_q <= '0;
                end else if (word_hs && (cnt_q == CNT_W'(gi))) begin
                    slice_q <= key_word[SW-1:0];
                end
            end

            assign working_key[LO +: SW] = slice_q;
        end
    endgenerate

    assign key_ready    = key_ready_q;
    assign key_err      = key_err_q;
    assign ap_start_out = host_start && key_ready_q;

endmodule : hls_macc_nc_key_loader
